// File: rtl/spmv_row_accum.sv
// ============================================================================
// spmv_row_accum
// ----------------------------------------------------------------------------
// Purpose
//   Row accumulator for a sparse matrix-vector multiply datapath. Products
//   A[i][j]*x[j] arrive as an FP32 stream, with a "last" flag marking the final
//   product of each row. The block folds each row into a single sum, strictly
//   left to right, by driving an external pipelined FP32 adder of unknown
//   latency (>= 1 cycle). At most one add is in flight at any time. The block
//   itself does no arithmetic: rounding, NaN and denormal behaviour all come
//   from the adder.
//
//   A row of k products issues exactly k-1 adds. A single-product row skips
//   the adder and presents the product bit-for-bit as the row sum one cycle
//   after it is accepted. Empty rows are not supported.
//
// Ports
//   clk               in   single clock, all logic on the rising edge
//   rstn              in   asynchronous, active-low reset
//   s_prod_data       in   FP32 product
//   s_prod_last       in   marks the final product of the current row
//   s_prod_valid      in   product stream valid
//   s_prod_ready      out  product stream ready
//   add_a             out  adder operand a (running sum)
//   add_b             out  adder operand b (newest product)
//   add_input_valid   out  operand pair valid (drives both adder a/b valid)
//   add_input_ready   in   adder takes the operand pair (a_ready & b_ready)
//   add_c             in   adder result
//   add_output_valid  in   adder result valid
//   add_output_ready  out  this block accepts the adder result
//   m_sum_data        out  completed row sum
//   m_sum_count       out  number of products in that row (saturating)
//   m_sum_valid       out  row sum valid
//   m_sum_ready       in   downstream accepts the row sum
//
// Every handshake output comes straight from a flop. There is no
// combinational path from any input to any output.
// ============================================================================
module spmv_row_accum #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,

    // product stream in
    input  logic [DATA_WIDTH-1:0] s_prod_data,
    input  logic                  s_prod_last,
    input  logic                  s_prod_valid,
    output logic                  s_prod_ready,

    // external adder, operand side
    output logic [DATA_WIDTH-1:0] add_a,
    output logic [DATA_WIDTH-1:0] add_b,
    output logic                  add_input_valid,
    input  logic                  add_input_ready,

    // external adder, result side
    input  logic [DATA_WIDTH-1:0] add_c,
    input  logic                  add_output_valid,
    output logic                  add_output_ready,

    // row sum out
    output logic [DATA_WIDTH-1:0] m_sum_data,
    output logic [CNT_WIDTH-1:0]  m_sum_count,
    output logic                  m_sum_valid,
    input  logic                  m_sum_ready
);

    // FIRST : wait for the first product of a row
    // NEXT  : wait for a subsequent product
    // ISSUE : present (acc, opnd) to the adder
    // WAIT  : wait for the adder result
    // EMIT  : present the finished row sum
    typedef enum logic [2:0] {
        FIRST = 3'd0,
        NEXT  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        EMIT  = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                state_q;
    logic [DATA_WIDTH-1:0] acc_q;        // running sum, also the emitted row sum
    logic [DATA_WIDTH-1:0] opnd_q;       // product waiting to be added
    logic [CNT_WIDTH-1:0]  cnt_q;        // products seen in the current row
    logic                  last_q;       // opnd_q is the last product of its row

    // Registered handshake outputs
    logic                  prod_ready_q;
    logic                  add_in_valid_q;
    logic                  add_out_ready_q;
    logic                  sum_valid_q;

    // Combinational next values and handshake qualifiers
    logic [CNT_WIDTH-1:0]  cnt_inc_d;
    logic                  prod_fire;
    logic                  add_in_fire;
    logic                  add_out_fire;
    logic                  sum_fire;

    // The counter saturates at all-ones and does not wrap. A very long row
    // therefore reports the maximum count, never a small bogus one.
    assign cnt_inc_d = (&cnt_q) ? cnt_q : (cnt_q + CNT_ONE);

    // Each handshake is qualified by its own registered enable. This gates
    // out inputs that arrive in the wrong state, such as a stray adder result
    // outside WAIT or a late result after a reset.
    assign prod_fire    = s_prod_valid     & prod_ready_q;
    assign add_in_fire  = add_in_valid_q   & add_input_ready;
    assign add_out_fire = add_output_valid & add_out_ready_q;
    assign sum_fire     = sum_valid_q      & m_sum_ready;

    // ------------------------------------------------------------------------
    // FSM and datapath registers.
    //
    // The handshake flags are registered together with the state transition,
    // so each flag always matches the state it belongs to. The one exception
    // is s_prod_ready in the first cycle after reset. Reset forces every
    // output low, so FIRST raises s_prod_ready on its first clock edge. From
    // then on, every transition into FIRST or NEXT sets it directly.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= FIRST;
            acc_q           <= '0;
            opnd_q          <= '0;
            cnt_q           <= '0;
            last_q          <= 1'b0;
            prod_ready_q    <= 1'b0;
            add_in_valid_q  <= 1'b0;
            add_out_ready_q <= 1'b0;
            sum_valid_q     <= 1'b0;
        end else begin
            unique case (state_q)
                FIRST: begin
                    prod_ready_q <= 1'b1;
                    if (prod_fire) begin
                        acc_q <= s_prod_data;
                        cnt_q <= CNT_ONE;
                        if (s_prod_last) begin
                            // Single-product row: the product is the sum.
                            state_q      <= EMIT;
                            prod_ready_q <= 1'b0;
                            sum_valid_q  <= 1'b1;
                        end else begin
                            state_q <= NEXT;
                        end
                    end
                end

                NEXT: begin
                    if (prod_fire) begin
                        opnd_q         <= s_prod_data;
                        last_q         <= s_prod_last;
                        cnt_q          <= cnt_inc_d;
                        state_q        <= ISSUE;
                        prod_ready_q   <= 1'b0;
                        add_in_valid_q <= 1'b1;
                    end
                end

                ISSUE: begin
                    // acc_q and opnd_q are left alone here, so add_a and
                    // add_b stay stable while the adder stalls.
                    if (add_in_fire) begin
                        state_q         <= WAIT;
                        add_in_valid_q  <= 1'b0;
                        add_out_ready_q <= 1'b1;
                    end
                end

                WAIT: begin
                    if (add_out_fire) begin
                        acc_q           <= add_c;
                        add_out_ready_q <= 1'b0;
                        if (last_q) begin
                            state_q     <= EMIT;
                            sum_valid_q <= 1'b1;
                        end else begin
                            state_q      <= NEXT;
                            prod_ready_q <= 1'b1;
                        end
                    end
                end

                EMIT: begin
                    if (sum_fire) begin
                        state_q      <= FIRST;
                        sum_valid_q  <= 1'b0;
                        prod_ready_q <= 1'b1;
                    end
                end

                default: begin
                    // Unreachable encodings go back to a clean idle state.
                    state_q         <= FIRST;
                    prod_ready_q    <= 1'b0;
                    add_in_valid_q  <= 1'b0;
                    add_out_ready_q <= 1'b0;
                    sum_valid_q     <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. The adder operands and the row sum are wired directly to the
    // holding registers. Those registers change only on a handshake, so the
    // outputs are stable for as long as their valid is held. All of them
    // read zero during reset.
    // ------------------------------------------------------------------------
    assign s_prod_ready     = prod_ready_q;
    assign add_input_valid  = add_in_valid_q;
    assign add_output_ready = add_out_ready_q;
    assign m_sum_valid      = sum_valid_q;

    assign add_a       = acc_q;
    assign add_b       = opnd_q;
    assign m_sum_data  = acc_q;
    assign m_sum_count = cnt_q;

endmodule
